// File: rtl/spi_controller.sv
// ----------------------------------------------------------------------------
// spi_controller
//   SPI mode-0 initiator. It sends 16-bit register-write frames, MSB first, to
//   the spi_peripheral register file:
//     [15]   = R/W (1 = write)
//     [14:8] = address
//     [7:0]  = data
//   SCLK is paced at HALF_DIV clk cycles per half-period. This gives the
//   peripheral's 2-flop synchroniser and edge detector enough time to see
//   every edge.
//
// Optional feature: `define SPI_READ_EN adds the CIPO input and the rsp_data
//   output. For read frames (rw = 0), the data byte is captured from the
//   peripheral.
//
// Parameters:
//   HALF_DIV    clk cycles per SCLK half-period (>= 3)
//   GAP_CYCLES  minimum clk cycles nCS stays high between frames (>= 3)
//
// Ports:
//   clk, rst_n  system clock; asynchronous active-low reset
//   req_valid   request present
//   req_ready   controller idle and able to accept a request
//   req_rw      frame bit 15 (1 = write)
//   req_addr    7-bit register address
//   req_data    8-bit write data
//   busy        a frame or the inter-frame gap is in progress (= ~req_ready)
//   done        1-cycle pulse when a frame completes (nCS rises)
//   nCS         chip select, active low
//   SCLK        SPI clock, idle low
//   COPI        serial data to the peripheral
//   CIPO        serial data from the peripheral  (SPI_READ_EN only)
//   rsp_data    captured read byte               (SPI_READ_EN only)
// ----------------------------------------------------------------------------
module spi_controller #(
    parameter int unsigned HALF_DIV   = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI
`ifdef SPI_READ_EN
    ,
    input  logic       CIPO,
    output logic [7:0] rsp_data
`endif
);

    localparam int unsigned CNT_MAX = (HALF_DIV > GAP_CYCLES) ? HALF_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    if (HALF_DIV < 3) begin : g_bad_half_div
        $error("spi_controller: HALF_DIV must be >= 3");
    end
    if (GAP_CYCLES < 3) begin : g_bad_gap_cycles
        $error("spi_controller: GAP_CYCLES must be >= 3");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       bit_q,   bit_d;
    logic [15:0]      shreg_q, shreg_d;
    logic             ncs_q,   ncs_d;
    logic             sclk_q,  sclk_d;
    logic             done_q,  done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
        end
    end

    // The phase counter is reloaded on every state entry and counts down to
    // zero. The last cycle of a phase is therefore the one with cnt_q == 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = LOW;
                    cnt_d   = HALF_LOAD;
                    bit_d   = '0;
                    shreg_d = {req_rw, req_addr, req_data};
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = HALF_LOAD;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    cnt_d  = HALF_LOAD;
                    sclk_d = 1'b0;
                    if (bit_q == 4'd15) begin
                        state_d = HOLD;
                    end else begin
                        state_d = LOW;
                        bit_d   = bit_q + 4'd1;
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                    ncs_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // COPI is taken directly from the shift-register MSB. It only moves on
    // accept and on the HIGH->LOW transition, so it changes while SCLK is low.
    assign COPI      = shreg_q[15];
    assign nCS       = ncs_q;
    assign SCLK      = sclk_q;
    assign done      = done_q;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

`ifdef SPI_READ_EN
    logic       cipo_meta, cipo_sync;
    logic       is_read_q;
    logic [7:0] rd_shift_q;
    logic [7:0] rsp_q;

    // Frame bits 8..15 (bit_q[3] set) carry data bits 7..0. Each bit is
    // sampled on the last HIGH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo_meta  <= 1'b0;
            cipo_sync  <= 1'b0;
            is_read_q  <= 1'b0;
            rd_shift_q <= '0;
            rsp_q      <= '0;
        end else begin
            cipo_meta <= CIPO;
            cipo_sync <= cipo_meta;
            if (state_q == IDLE && req_valid) begin
                is_read_q <= ~req_rw;
            end
            if (state_q == HIGH && cnt_q == '0 && bit_q[3]) begin
                rd_shift_q <= {rd_shift_q[6:0], cipo_sync};
            end
            if (state_q == HOLD && cnt_q == '0 && is_read_q) begin
                rsp_q <= rd_shift_q;
            end
        end
    end

    assign rsp_data = rsp_q;
`endif

endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;

    localparam int unsigned HD = 4;
    localparam int unsigned GC = 8;
    localparam int unsigned NCS_LOW = 33 * HD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, busy, done, nCS, SCLK, COPI;
`ifdef SPI_READ_EN
    logic       CIPO = 1'b0;
    logic [7:0] rsp_data;
`endif

    spi_controller #(
        .HALF_DIV   (HD),
        .GAP_CYCLES (GC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .busy      (busy),
        .done      (done),
        .nCS       (nCS),
        .SCLK      (SCLK),
        .COPI      (COPI)
`ifdef SPI_READ_EN
        ,
        .CIPO      (CIPO),
        .rsp_data  (rsp_data)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] frame;
        bit          b2b;
        logic [7:0]  rd_byte;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        m_prev_sclk = 1'b0, m_prev_ncs = 1'b1, m_prev_copi = 1'b0, m_prev_done = 1'b0;
    bit          m_have_prev = 0;
    logic [15:0] m_bits = '0;
    int          m_nbits = 0, m_low = 0, m_high = 0;
`ifdef SPI_READ_EN
    logic [7:0]  model_rsp = '0;
`endif

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_prev_sclk = 1'b0; m_prev_ncs = 1'b1; m_prev_copi = 1'b0; m_prev_done = 1'b0;
            m_have_prev = 0; m_nbits = 0; m_low = 0; m_high = 0;
`ifdef SPI_READ_EN
            model_rsp = '0;
`endif
        end else begin
            check("busy_vs_ready", busy, !req_ready);
            if (done) begin
                check("done_with_ncs_high", nCS, 1);
                check("done_single_cycle", m_prev_done, 0);
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: got frame 0x%0h, required none", m_bits);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bits", m_bits, e.frame);
                    check("sclk_rises", m_nbits, 16);
                    check("ncs_low_cycles", m_low, NCS_LOW);
`ifdef SPI_READ_EN
                    if (!e.frame[15]) model_rsp = e.rd_byte;
                    check("rsp_data", rsp_data, model_rsp);
`endif
                end
                m_have_prev = 1;
                m_high = 0;
            end
            if (!nCS && m_prev_ncs) begin
                if (m_have_prev) begin
                    if (exp_q.size() > 0 && exp_q[0].b2b)
                        check("gap_exact", m_high, GC + 1);
                    else
                        check("gap_min", m_high >= GC + 1, 1);
                end
                m_low = 0; m_nbits = 0; m_bits = '0;
            end
            if (!nCS) begin
                m_low++;
                if (SCLK && !m_prev_sclk) begin
                    m_bits = {m_bits[14:0], COPI};
                    m_nbits++;
`ifdef SPI_READ_EN
                    if (m_nbits >= 9 && m_nbits <= 16 && exp_q.size() > 0 && !exp_q[0].frame[15])
                        CIPO = exp_q[0].rd_byte[16 - m_nbits];
`endif
                end
                if (SCLK) check("copi_stable_sclk_high", COPI, m_prev_copi);
            end else begin
                m_high++;
            end
            m_prev_sclk = SCLK; m_prev_ncs = nCS; m_prev_copi = COPI; m_prev_done = done;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_chk++; n_fail++;
            $display("FAIL ready_timeout: got req_ready=0, required 1");
        end
    endtask

    // Presents a request at a negedge. Returns just after the accept edge, with valid still high.
    task automatic issue(input logic [15:0] f, input bit b2b, input logic [7:0] rb);
        exp_t e;
        wait_ready();
        req_rw = f[15]; req_addr = f[14:8]; req_data = f[7:0];
        req_valid = 1'b1;
        e.frame = f; e.b2b = b2b; e.rd_byte = rb;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    // Counts the negedge samples with req_ready low after an accept edge.
    task automatic check_busy_span();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("accept_to_ready", n, NCS_LOW + GC);
    endtask

    task automatic single(input logic [15:0] f, input logic [7:0] rb);
        issue(f, 0, rb);
        req_valid = 1'b0;
        req_rw = $urandom; req_addr = $urandom; req_data = $urandom;
        check_busy_span();
    endtask

    initial begin
        logic [15:0] f;
        int rises;
        logic ps;

        repeat (3) @(negedge clk);
        check("rst_ncs", nCS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_copi", COPI, 0);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef SPI_READ_EN
        check("rst_rsp", rsp_data, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        single(16'h84A5, 8'h00);

        // back-to-back with req_valid held high
        issue(16'h8001, 0, 8'h00);
        req_rw = 1'b1; req_addr = 7'h01; req_data = 8'hFF;
        begin
            exp_t e;
            e.frame = 16'h81FF; e.b2b = 1; e.rd_byte = 8'h00;
            exp_q.push_back(e);
        end
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_busy_span();

`ifdef SPI_READ_EN
        single(16'h023C & 16'h7F00, 8'h3C);
        single(16'h8511, 8'h00);
`endif

        // randomized frames with random idle gaps
        for (int i = 0; i < 8; i++) begin
            f = 16'($urandom);
            single(f, 8'($urandom));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // reset at the 9th SCLK rise of a frame
        issue(16'($urandom), 0, 8'($urandom));
        req_valid = 1'b0;
        rises = 0; ps = 1'b0;
        for (int t = 0; t < 2000 && rises < 9; t++) begin
            @(negedge clk);
            if (SCLK && !ps) rises++;
            ps = SCLK;
        end
        check("rises_before_reset", rises, 9);
        rst_n = 1'b0;
        #1;
        check("abort_ncs", nCS, 1);
        check("abort_sclk", SCLK, 0);
        check("abort_done", done, 0);
        check("abort_ready", req_ready, 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        check("abort_no_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        single(16'h8233, 8'h00);

        begin
            int t = 0;
            while (exp_q.size() > 0 && t < 2000) begin
                @(negedge clk);
                t++;
            end
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
